// File: rtl/adder_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_seq_ctrl_pkg
//  Brief    : Shared constants for the nibble-serial adder (FSM codes, nibble width).
//  Revision : 1.0  initial release
// ============================================================================
package adder_seq_ctrl_pkg;

    localparam int NIB_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef logic [NIB_W-1:0] nibble_t;

    function automatic int nnib(input int width);
        return width / NIB_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : adder_seq_ctrl_if
//  Brief    : Request/result bundle between a requester and the serial adder.
//  Revision : 1.0  initial release
// ============================================================================
interface adder_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             done;

    modport master (
        output start, a, b, c,
        input  ready, busy, sum, carry, done
    );

    modport slave (
        input  start, a, b, c,
        output ready, busy, sum, carry, done
    );
endinterface
`default_nettype wire

// File: rtl/adder_seq_ctrl_adder_nibble.sv
`default_nettype none
// ============================================================================
//  Module   : adder_nibble
//  Brief    : Combinational 4-bit adder with carry in/out.
//  Revision : 1.0  initial release
// ============================================================================
module adder_nibble
    import adder_seq_ctrl_pkg::*;
(
    input  wire nibble_t x,
    input  wire nibble_t y,
    input  wire logic    cin,
    output nibble_t      s,
    output logic         cout
);
    assign {cout, s} = {1'b0, x} + {1'b0, y} + {{NIB_W{1'b0}}, cin};
endmodule
`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : adder_seq_ctrl
//  Brief    : Adds two WIDTH-bit operands one nibble per cycle through one 4-bit adder.
//  Revision : 1.0  initial release
// ============================================================================
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    adder_seq_ctrl_if.slave bus
);
    localparam int NNIB  = nnib(WIDTH);
    localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("adder_seq_ctrl: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] ws_q,    ws_d;
    logic             cy_q,    cy_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             carry_q, carry_d;

    nibble_t nib_x, nib_y, nib_s;
    logic    nib_co;

    assign nib_x = a_q[int'(idx_q)*NIB_W +: NIB_W];
    assign nib_y = b_q[int'(idx_q)*NIB_W +: NIB_W];

    adder_nibble u_adder_nibble (
        .x    (nib_x),
        .y    (nib_y),
        .cin  (cy_q),
        .s    (nib_s),
        .cout (nib_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        ws_d    = ws_q;
        cy_d    = cy_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cy_d    = bus.c;
                    ws_d    = '0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ws_d[int'(idx_q)*NIB_W +: NIB_W] = nib_s;
                cy_d  = nib_co;
                idx_d = idx_q + 1'b1;
                // Outputs only change once the final nibble is in, so partial sums never leak.
                if (idx_q == LAST_IDX) begin
                    sum_d   = ws_d;
                    carry_d = nib_co;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ws_q    <= '0;
            cy_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ws_q    <= ws_d;
            cy_q    <= cy_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.ready = (state_q == ST_IDLE);
    assign bus.busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;

endmodule
`default_nettype wire

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived constant: NNIB, WIDTH/4, nibble count per operation (4 at default).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; accepted only on a rising edge where ready=1.
REQ-006 a  input  WIDTH  operand A, sampled at acceptance.
REQ-007 b  input  WIDTH  operand B, sampled at acceptance.
REQ-008 c  input  1  carry-in, sampled at acceptance.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 busy  output  1  high in RUN and DONE.
REQ-011 sum  output  WIDTH  registered result of last completed operation.
REQ-012 carry  output  1  registered carry-out of last completed operation.
REQ-013 done  output  1  one-cycle pulse, high only in DONE.

Function
REQ-014 The block SHALL compute {carry,sum} = a + b + c using one shared 4-bit adder, one nibble per cycle, LSB nibble first.
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 IDLE: edge with start=1 latches a, b, c into working registers, clears nibble index to 0, moves to RUN; start=0 stays in IDLE.
REQ-017 RUN: each edge adds nibble[idx] of A and B plus stored carry, writes the 4-bit result into working-sum nibble[idx], stores adder carry-out, increments idx.
REQ-018 RUN: on the edge processing idx=NNIB-1, the full working sum and final carry SHALL be copied to sum/carry and state SHALL move to DONE.
REQ-019 DONE: exactly one cycle; next edge returns to IDLE unconditionally.
REQ-020 Latency: acceptance on edge E0, nibbles processed on E1..ENNIB, done high between ENNIB and ENNIB+1; at default, done rises 4 edges after acceptance.
REQ-021 Throughput: with start held high, operations SHALL be accepted every NNIB+2 edges (6 at default).
REQ-022 start asserted in RUN or DONE SHALL be ignored; operand changes after acceptance SHALL NOT affect the result.
REQ-023 sum/carry SHALL hold their previous value during RUN; partial results SHALL never be visible on outputs.
REQ-024 Carry SHALL propagate between nibbles through the stored carry register only; no combinational path from a/b/c to any output.
REQ-025 Overflow beyond WIDTH bits SHALL appear only on carry; sum wraps modulo 2^WIDTH.

Reset
REQ-026 rst=1 SHALL force, without waiting for clk: state IDLE, idx 0, working registers 0, sum 0, carry 0, done 0, busy 0, ready 1.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse; first edge after deassertion behaves as IDLE.

Structure
REQ-028 A shared package/include SHALL hold FSM state encodings, nibble width constant (4) and NNIB derivation.
REQ-029 The 4-bit adder SHALL be a separate combinational sub-module, adder_nibble (inputs 4-bit x, y, cin; outputs 4-bit s, cout), instantiated exactly once.

Verification
REQ-030 a=0x1234, b=0x4321, c=0 -> sum=0x5555, carry=0, done 4 edges after acceptance, ready low for 5 cycles.
REQ-031 a=0xFFFF, b=0x0001, c=0 -> sum=0x0000, carry=1 (ripple through all nibbles).
REQ-032 a=0xFFFF, b=0xFFFF, c=1 -> sum=0xFFFF, carry=1.
REQ-033 Accept 0x0010+0x0020, then pulse start with 0xAAAA+0x5555 during RUN -> result 0x0030, carry 0, single done pulse.
REQ-034 Accept 0x00FF+0x0001, assert rst after 2 nibble edges -> sum=0, carry=0, ready=1 immediately, no done; next 0x0003+0x0004 -> 0x0007.
REQ-035 start held high, 3 back-to-back operations -> acceptances 6 edges apart, three done pulses, each result correct.
